mac8_add_sequencer: RTL
=======================

# mac8_add_sequencer

Sequencer for the MAC8 datapath. It time-shares the single external 16-bit reversible adder to perform an unsigned 8x8 shift-and-add multiply, then adds the product into a 16-bit accumulator. Operands arrive on a valid/ready input channel, and the accumulated result leaves on a valid/ready output channel. The adder stays outside this block: the sequencer drives its operands and reads back its combinational sum.

## Interface

Parameters: none. All widths are fixed: 8-bit operands, 16-bit product, 16-bit accumulator.

- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  operand pair present
- in_ready  out  1  sequencer can accept; high only in IDLE
- in_a  in  8  multiplicand, unsigned
- in_b  in  8  multiplier, unsigned
- in_clr  in  1  qualified by in_valid; this transaction's product replaces the accumulator instead of adding to it
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_acc  out  16  accumulator register, always visible
- out_ovf  out  1  sticky unsigned-overflow flag of the accumulator
- add_a  out  16  adder operand A
- add_b  out  16  adder operand B
- add_cin  out  1  adder carry-in; always 0
- add_sum  in  16  adder result; combinational function of add_a, add_b and add_cin within the same cycle

## Operation

- States: IDLE, MUL, ACC, DONE.
- **IDLE:**
  - in_ready=1; add_a=acc, add_b=0.
  - When in_valid is high at a rising edge, latch a_r=in_a, b_r=in_b, clr_r=in_clr, set P=0 and k=0, and go to MUL.
- **MUL (8 cycles, k=0..7):**
  - add_a=P; add_b = b_r[k] ? ({8'b0,a_r} << k) : 16'h0000.
  - P <= add_sum; k <= k+1.
  - After the cycle with k=7, go to ACC. The 3-bit counter k wraps to 0.
- **ACC (1 cycle):**
  - add_a = clr_r ? 0 : acc; add_b=P.
  - acc <= add_sum.
  - The carry-out is derived from the MSBs: c = (add_a[15]&add_b[15]) | ((add_a[15]|add_b[15]) & ~add_sum[15]).
  - If clr_r, out_ovf <= 0; otherwise out_ovf <= out_ovf | c.
  - Go to DONE.
- **DONE:**
  - out_valid=1; add_a=acc, add_b=0.
  - Go to IDLE on the rising edge where out_ready=1.
- Arithmetic rules:
  - The product is exact: max 255*255 = 65025 fits in 16 bits.
  - Accumulation wraps modulo 2^16.
  - add_cin is tied to 0 in every state.
- in_valid outside IDLE is ignored and no data is latched. in_clr is meaningful only in the accept cycle.
- Reset (rst_n=0 at a rising edge) overrides everything, including mid-MUL or mid-ACC. It forces:
  - state=IDLE, acc=0, out_ovf=0, P=0, k=0, out_valid=0
  - in_ready=1 in the cycle after the reset edge

## Timing

- Reset values: in_ready=1, out_valid=0, out_acc=0, out_ovf=0, add_a=0, add_b=0, add_cin=0.
- Acceptance occurs at edge E0. MUL occupies the cycles after edges E0..E7, and ACC the cycle after E8.
- Edge E9 updates out_acc/out_ovf and raises out_valid. Latency from acceptance to out_valid is 9 clocks.
- out_acc changes only at the ACC-exit edge or at reset. It is stable throughout DONE and IDLE.
- out_valid and out_acc hold indefinitely while out_ready=0.
- The output handshake completes at an edge with out_valid&out_ready. in_ready rises in the following cycle.
- Minimum spacing between acceptances is 11 clocks, reached when out_ready is held high.
- add_sum is consumed in the same cycle it is produced; the external adder path must close within one clock.
- No combinational path exists from in_valid or out_ready to any output.

## Test plan

- **Reset:** hold rst_n=0 for 2 cycles -> in_ready=1, out_valid=0, out_acc=0, out_ovf=0, add_a=add_b=0.
- **Basic clear:** in_a=3, in_b=5, in_clr=1 -> out_valid rises 9 clocks after acceptance with out_acc=15 and out_ovf=0. Trace P through MUL as 3,3,15,15,15,15,15,15.
- **Accumulate with overflow:** 255*255 with clr=1, then 255*255 with clr=0 -> out_acc=65025, then 64514, with out_ovf=1. A third transaction of 0*7 with clr=0 -> out_acc=64514, out_ovf stays 1. A fourth of 1*1 with clr=1 -> out_acc=1, out_ovf=0.
- **Backpressure:** hold out_ready=0 for 5 cycles in DONE -> out_valid=1 and out_acc stable throughout, in_ready=0. Then raise out_ready -> in_ready=1 in the next cycle.
- **Busy input:** drive in_valid=1 with new operands during MUL -> in_ready=0 and the result is unaffected.
- **Reset mid-operation:** assert rst_n=0 at the fourth MUL cycle after acc=100 -> acc=0, state IDLE. A next transaction of 2*2 with clr=0 -> out_acc=4.

Source files
------------

// File: rtl/mac8_add_sequencer.sv
// MAC8 sequencer: shift-and-add 8x8 multiply on a shared external 16-bit adder,
// then accumulate the product into a 16-bit register with a sticky overflow flag.
module mac8_add_sequencer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_a,
   input  logic [7:0]  in_b,
   input  logic        in_clr,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_acc,
   output logic        out_ovf,
   output logic [15:0] add_a,
   output logic [15:0] add_b,
   output logic        add_cin,
   input  logic [15:0] add_sum
);

   typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

   state_t      state;
   logic [7:0]  a_r;
   logic [7:0]  b_r;
   logic        clr_r;
   logic [15:0] p;
   logic [2:0]  k;
   logic        carry;

   // Adder operands depend only on registered state, never on in_valid/out_ready.
   always_comb begin
      add_a = out_acc;
      add_b = '0;
      case (state)
         MUL: begin
            add_a = p;
            add_b = b_r[k] ? ({8'b0, a_r} << k) : '0;
         end
         ACC: begin
            add_a = clr_r ? '0 : out_acc;
            add_b = p;
         end
         default: ;
      endcase
   end

   assign add_cin = 1'b0;

   // Carry-out of the accumulate add, recovered from the operand and sum MSBs.
   assign carry = (add_a[15] & add_b[15]) | ((add_a[15] | add_b[15]) & ~add_sum[15]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_r       <= '0;
         b_r       <= '0;
         clr_r     <= 1'b0;
         p         <= '0;
         k         <= '0;
         out_acc   <= '0;
         out_ovf   <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r      <= in_a;
                  b_r      <= in_b;
                  clr_r    <= in_clr;
                  p        <= '0;
                  k        <= '0;
                  in_ready <= 1'b0;
                  state    <= MUL;
               end
            end
            MUL: begin
               p <= add_sum;
               k <= k + 3'd1;
               if (k == 3'd7) state <= ACC;
            end
            ACC: begin
               out_acc   <= add_sum;
               out_ovf   <= clr_r ? 1'b0 : (out_ovf | carry);
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
